// File: rtl/bcd_digit_entry.sv
// Decimal digit entry: debounced/synchronised key presses shift BCD digits into a binary value.
// Optional key debounce is enabled by defining BCD_DEBOUNCE_EN.
module bcd_digit_entry #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned BIN_W      = 7,
  parameter int unsigned DB_CYCLES  = 16
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [3:0]              digit_in,
  input  logic                    enter_n,
  input  logic                    clear,
  output logic [BIN_W-1:0]        value,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [2:0]              digit_count,
  output logic                    full,
  output logic                    err_invalid,
  output logic                    err_overflow
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam bit ParamsOk = (NUM_DIGITS >= 1) && (NUM_DIGITS <= 4) && (DB_CYCLES >= 1) &&
                            ((64'd1 << BIN_W) >= 64'(10 ** NUM_DIGITS));

  if (!ParamsOk) begin : g_bad_params
    $error("bcd_digit_entry: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } state_e;

  state_e state;

  logic sync1, sync2;
  logic key_lvl;
  logic prev_lvl;
  logic press;

  // Synchroniser flops reset to the released (high) key level.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= enter_n;
      sync2 <= sync1;
    end
  end

`ifdef BCD_DEBOUNCE_EN
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CW-1:0] db_cnt;
  logic          db_lvl;

  // The debounced level only follows sync2 after DB_CYCLES consecutive differing samples.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      db_lvl <= 1'b1;
      db_cnt <= '0;
    end else if (sync2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
      db_lvl <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign key_lvl = db_lvl;
`else
  assign key_lvl = sync2;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      prev_lvl <= 1'b1;
    end else begin
      prev_lvl <= key_lvl;
    end
  end

  assign press = prev_lvl & ~key_lvl;

  logic             digit_ok;
  logic [BIN_W-1:0] value_mac;
  logic [DW-1:0]    digits_shift;
  logic [2:0]       count_inc;

  assign digit_ok     = (digit_in <= 4'd9);
  assign value_mac    = (value << 3) + (value << 1) + BIN_W'(digit_in);
  assign digits_shift = (digits_bcd << 4) | DW'(digit_in);
  assign count_inc    = digit_count + 3'd1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= StEmpty;
      value        <= '0;
      digits_bcd   <= '1;
      digit_count  <= '0;
      full         <= 1'b0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
      if (clear) begin
        // Clear beats a coincident press and suppresses its error pulse.
        state       <= StEmpty;
        value       <= '0;
        digits_bcd  <= '1;
        digit_count <= '0;
        full        <= 1'b0;
      end else if (press) begin
        if (!digit_ok) begin
          err_invalid <= 1'b1;
        end else begin
          case (state)
            StEmpty, StPartial: begin
              value       <= value_mac;
              digits_bcd  <= digits_shift;
              digit_count <= count_inc;
              if (count_inc == 3'(NUM_DIGITS)) begin
                state <= StFull;
                full  <= 1'b1;
              end else begin
                state <= StPartial;
              end
            end
            StFull: begin
              err_overflow <= 1'b1;
            end
            default: begin
              state <= StEmpty;
            end
          endcase
        end
      end
    end
  end

endmodule
